// File: rtl/history_buffer.sv
// Guess-history store for the code-breaking game: records committed guesses with
// their scores and lets the player browse past turns through a registered read port.
module history_buffer #(
  parameter  int PEGS    = 4,
  parameter  int COLOR_W = 3,
  parameter  int TURNS   = 8,
  parameter  int WRAP    = 0,
  localparam int IDX_W   = $clog2(TURNS),
  localparam int CNT_W   = $clog2(TURNS + 1),
  localparam int SCORE_W = $clog2(PEGS + 1),
  localparam int GW      = PEGS * COLOR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_select,
  input  logic [GW-1:0]      guess,
  input  logic [SCORE_W-1:0] score_exact,
  input  logic [SCORE_W-1:0] score_partial,
  output logic [GW-1:0]      selection,
  output logic [SCORE_W-1:0] sel_exact,
  output logic [SCORE_W-1:0] sel_partial,
  output logic               sel_valid,
  output logic [IDX_W-1:0]   selected_turn,
  output logic [CNT_W-1:0]   turn_count,
  output logic               last_turn,
  output logic               full,
  output logic               commit_ack
);

  logic [CNT_W-1:0]                r_tc;
  logic [IDX_W-1:0]                r_sel;
  logic [TURNS-1:0][GW-1:0]        r_g;
  logic [TURNS-1:0][SCORE_W-1:0]   r_e;
  logic [TURNS-1:0][SCORE_W-1:0]   r_p;
  logic [GW-1:0]                   r_sg;
  logic [SCORE_W-1:0]              r_se;
  logic [SCORE_W-1:0]              r_sp;
  logic                            r_ack;

  logic                            w_full;
  logic                            w_empty;
  logic                            w_commit;
  logic [CNT_W-1:0]                w_tc_m1;
  logic [IDX_W-1:0]                w_newest;
  logic [IDX_W-1:0]                w_wr_idx;
  logic [IDX_W-1:0]                w_sel_nxt;

  assign w_full   = (r_tc == CNT_W'(TURNS));
  assign w_empty  = (r_tc == '0);
  assign w_commit = !mode && btn_select && !w_full;
  assign w_tc_m1  = r_tc - CNT_W'(1);
  assign w_newest = w_empty ? '0 : w_tc_m1[IDX_W-1:0];
  assign w_wr_idx = r_tc[IDX_W-1:0];

  // In guess mode the index always tracks the newest entry, so entering browse
  // mode naturally starts there and any same-cycle step applies on top of it.
  always_comb begin
    w_sel_nxt = r_sel;
    if (!mode) begin
      w_sel_nxt = w_commit ? w_wr_idx : w_newest;
    end else if (w_empty) begin
      w_sel_nxt = '0;
    end else if (btn_up && !btn_down) begin
      if (r_sel == w_newest) w_sel_nxt = (WRAP != 0) ? '0 : r_sel;
      else                   w_sel_nxt = r_sel + IDX_W'(1);
    end else if (btn_down && !btn_up) begin
      if (r_sel == '0) w_sel_nxt = (WRAP != 0) ? w_newest : '0;
      else             w_sel_nxt = r_sel - IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tc  <= '0;
      r_sel <= '0;
      r_g   <= '0;
      r_e   <= '0;
      r_p   <= '0;
      r_sg  <= '0;
      r_se  <= '0;
      r_sp  <= '0;
      r_ack <= 1'b0;
    end else begin
      r_sel <= w_sel_nxt;
      r_ack <= w_commit;
      if (w_commit) begin
        r_g[w_wr_idx] <= guess;
        r_e[w_wr_idx] <= score_exact;
        r_p[w_wr_idx] <= score_partial;
        r_tc          <= r_tc + CNT_W'(1);
      end
      // Registered read of the currently selected entry; blanked while empty.
      r_sg <= w_empty ? '0 : r_g[r_sel];
      r_se <= w_empty ? '0 : r_e[r_sel];
      r_sp <= w_empty ? '0 : r_p[r_sel];
    end
  end

  assign selection     = r_sg;
  assign sel_exact     = r_se;
  assign sel_partial   = r_sp;
  assign sel_valid     = !w_empty;
  assign selected_turn = r_sel;
  assign turn_count    = r_tc;
  assign last_turn     = (r_tc == CNT_W'(TURNS - 1));
  assign full          = w_full;
  assign commit_ack    = r_ack;

endmodule

// File: tb/tb_history_buffer.sv
// Bench for history_buffer: saturating and wrapping instances driven in parallel,
// checked every cycle against a turn-list model of the game history.
module tb_history_buffer;
  localparam int PEGS = 4, COLOR_W = 3, TURNS = 8;
  localparam int GW = PEGS * COLOR_W, SW = 3, IW = 3, CW = 4;

  logic clk = 1'b0;
  logic reset, mode, btn_up, btn_down, btn_select;
  logic [GW-1:0] guess;
  logic [SW-1:0] score_exact, score_partial;

  logic [GW-1:0] selection [2];
  logic [SW-1:0] sel_exact [2];
  logic [SW-1:0] sel_partial [2];
  logic          sel_valid [2];
  logic [IW-1:0] selected_turn [2];
  logic [CW-1:0] turn_count [2];
  logic          last_turn [2];
  logic          full [2];
  logic          commit_ack [2];

  always #5 clk = ~clk;

  for (genvar w = 0; w < 2; w++) begin : g_dut
    history_buffer #(.PEGS(PEGS), .COLOR_W(COLOR_W), .TURNS(TURNS), .WRAP(w)) u_dut (
      .clk(clk), .reset(reset), .mode(mode), .btn_up(btn_up), .btn_down(btn_down),
      .btn_select(btn_select), .guess(guess), .score_exact(score_exact),
      .score_partial(score_partial), .selection(selection[w]), .sel_exact(sel_exact[w]),
      .sel_partial(sel_partial[w]), .sel_valid(sel_valid[w]), .selected_turn(selected_turn[w]),
      .turn_count(turn_count[w]), .last_turn(last_turn[w]), .full(full[w]),
      .commit_ack(commit_ack[w]));
  end

  // Reference model: list of committed turns plus a browse cursor per instance.
  int            m_tc, m_ack;
  int            m_idx [2];
  logic [GW-1:0] m_g [TURNS];
  logic [SW-1:0] m_e [TURNS], m_p [TURNS];
  logic [GW-1:0] d_g [2];
  logic [SW-1:0] d_e [2], d_p [2];

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_step();
    bit commit;
    int ntc;
    if (reset) begin
      m_tc = 0; m_ack = 0;
      for (int w = 0; w < 2; w++) begin m_idx[w] = 0; d_g[w] = '0; d_e[w] = '0; d_p[w] = '0; end
      for (int t = 0; t < TURNS; t++) begin m_g[t] = '0; m_e[t] = '0; m_p[t] = '0; end
    end else begin
      commit = !mode && btn_select && (m_tc < TURNS);
      ntc = m_tc + (commit ? 1 : 0);
      for (int w = 0; w < 2; w++) begin
        d_g[w] = (m_tc != 0) ? m_g[m_idx[w]] : '0;
        d_e[w] = (m_tc != 0) ? m_e[m_idx[w]] : '0;
        d_p[w] = (m_tc != 0) ? m_p[m_idx[w]] : '0;
        if (!mode) m_idx[w] = (ntc == 0) ? 0 : ntc - 1;
        else if (m_tc == 0) m_idx[w] = 0;
        else if (btn_up && !btn_down)
          m_idx[w] = (w == 1) ? (m_idx[w] + 1) % m_tc
                              : ((m_idx[w] + 1 > m_tc - 1) ? m_tc - 1 : m_idx[w] + 1);
        else if (btn_down && !btn_up)
          m_idx[w] = (w == 1) ? (m_idx[w] + m_tc - 1) % m_tc
                              : ((m_idx[w] == 0) ? 0 : m_idx[w] - 1);
      end
      if (commit) begin
        m_g[m_tc] = guess; m_e[m_tc] = score_exact; m_p[m_tc] = score_partial;
      end
      m_tc  = ntc;
      m_ack = commit ? 1 : 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int w = 0; w < 2; w++) begin
      chk($sformatf("selection%0d", w), 32'(selection[w]), 32'(d_g[w]));
      chk($sformatf("sel_exact%0d", w), 32'(sel_exact[w]), 32'(d_e[w]));
      chk($sformatf("sel_partial%0d", w), 32'(sel_partial[w]), 32'(d_p[w]));
      chk($sformatf("sel_valid%0d", w), 32'(sel_valid[w]), 32'(m_tc != 0));
      chk($sformatf("selected_turn%0d", w), 32'(selected_turn[w]), 32'(m_idx[w]));
      chk($sformatf("turn_count%0d", w), 32'(turn_count[w]), 32'(m_tc));
      chk($sformatf("last_turn%0d", w), 32'(last_turn[w]), 32'(m_tc == TURNS - 1));
      chk($sformatf("full%0d", w), 32'(full[w]), 32'(m_tc == TURNS));
      chk($sformatf("commit_ack%0d", w), 32'(commit_ack[w]), 32'(m_ack));
    end
  endtask

  task automatic drive(input bit r, input bit m, input bit u, input bit d, input bit s);
    reset = r; mode = m; btn_up = u; btn_down = d; btn_select = s;
    guess = GW'($urandom); score_exact = SW'($urandom); score_partial = SW'($urandom);
    tick();
    btn_up = 1'b0; btn_down = 1'b0; btn_select = 1'b0; reset = 1'b0;
  endtask

  task automatic idle(input bit m);
    drive(1'b0, m, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_select = 1'b0;
    guess = '0; score_exact = '0; score_partial = '0;
    do_reset(); do_reset();

    // First commit: 1-0-0-0 scored (1,0)
    mode = 1'b0; btn_select = 1'b1; guess = 12'h001; score_exact = 3'd1; score_partial = 3'd0;
    tick();
    btn_select = 1'b0;
    idle(1'b0); idle(1'b0);

    // Fill to TURNS, then one extra select that must be ignored
    for (int i = 0; i < TURNS; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(1'b0);
    end
    idle(1'b1); idle(1'b0);

    // Browse over three stored turns
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0); idle(1'b1); end
    for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); idle(1'b1); end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0); idle(1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0); idle(1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0); idle(1'b1);
    idle(1'b0); idle(1'b0);

    // Browse with an empty history; select in browse mode is ignored
    do_reset();
    idle(1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b1); idle(1'b0);

    // Reset mid-browse together with an up step, then commit lands at index 0
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    chk("browse_idx3", 32'(selected_turn[0]), 32'd3);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_tc", 32'(turn_count[0]), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0); idle(1'b0);

    // Randomized phase
    mode = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      bit m;
      m = mode;
      if ($urandom_range(7) == 0) m = !m;
      drive($urandom_range(199) == 0, m, $urandom_range(2) == 0,
            $urandom_range(2) == 0, $urandom_range(2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
